// File: rtl/cdb_arbiter_if.sv
// Bundle of functional-unit completion ports, ROB/flush inputs and the CDB
// broadcast for cdb_arbiter.
interface cdb_arbiter_if;
  logic        alu_valid, b_valid, mem_valid;
  logic [4:0]  alu_rob_tag, b_rob_tag, mem_rob_tag;
  logic [6:0]  alu_pd, b_pd, mem_pd;
  logic [31:0] alu_data, b_data, mem_data;
  logic        alu_we, b_we, mem_we;
  logic        alu_ready, b_ready, mem_ready;
  logic [4:0]  rob_head;
  logic        mispredict;
  logic [4:0]  mispredict_tag;
  logic        cdb_valid;
  logic [4:0]  cdb_rob_tag;
  logic [6:0]  cdb_pd;
  logic [31:0] cdb_data;
  logic        cdb_we;

  modport slave (
    input  alu_valid, b_valid, mem_valid,
    input  alu_rob_tag, b_rob_tag, mem_rob_tag,
    input  alu_pd, b_pd, mem_pd,
    input  alu_data, b_data, mem_data,
    input  alu_we, b_we, mem_we,
    output alu_ready, b_ready, mem_ready,
    input  rob_head, mispredict, mispredict_tag,
    output cdb_valid, cdb_rob_tag, cdb_pd, cdb_data, cdb_we
  );

  modport master (
    output alu_valid, b_valid, mem_valid,
    output alu_rob_tag, b_rob_tag, mem_rob_tag,
    output alu_pd, b_pd, mem_pd,
    output alu_data, b_data, mem_data,
    output alu_we, b_we, mem_we,
    input  alu_ready, b_ready, mem_ready,
    output rob_head, mispredict, mispredict_tag,
    input  cdb_valid, cdb_rob_tag, cdb_pd, cdb_data, cdb_we
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: one in-order FIFO per functional unit, oldest-first
// selection by ROB age, branch-flush squashing, registered single broadcast.
module cdb_arbiter #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic          clk,
  input logic          reset,
  cdb_arbiter_if.slave bus
);
  localparam int unsigned PW      = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW + 1)'(FIFO_DEPTH);

  typedef struct packed {
    logic [4:0]  rob_tag;
    logic [6:0]  pd;
    logic [31:0] data;
    logic        we;
  } payload_t;

  typedef struct packed {
    payload_t p;
    logic     live;
  } entry_t;

  function automatic logic [4:0] age_of(input logic [4:0] tag, input logic [4:0] head);
    age_of = tag - head;
  endfunction

  payload_t      in_p     [3];
  logic          in_valid [3];
  entry_t        fifo_q   [3][FIFO_DEPTH];
  logic [PW-1:0] wr_ptr   [3];
  logic [PW-1:0] rd_ptr   [3];
  logic [PW:0]   count    [3];
  logic          ready    [3];
  logic          push     [3];
  logic          push_live[3];
  logic          pop      [3];
  logic          discard  [3];
  logic          elig     [3];
  entry_t        head_e   [3];
  logic [4:0]    head_age [3];
  logic [4:0]    flush_age;

  logic          sel_any;
  logic [1:0]    sel_idx;
  logic [4:0]    best_age;
  payload_t      sel_p;

  logic          cdb_valid_q;
  payload_t      cdb_q;

  always_comb begin
    in_valid[0] = bus.alu_valid;
    in_valid[1] = bus.b_valid;
    in_valid[2] = bus.mem_valid;
    in_p[0]     = '{rob_tag: bus.alu_rob_tag, pd: bus.alu_pd, data: bus.alu_data, we: bus.alu_we};
    in_p[1]     = '{rob_tag: bus.b_rob_tag,   pd: bus.b_pd,   data: bus.b_data,   we: bus.b_we};
    in_p[2]     = '{rob_tag: bus.mem_rob_tag, pd: bus.mem_pd, data: bus.mem_data, we: bus.mem_we};
  end

  assign flush_age = age_of(bus.mispredict_tag, bus.rob_head);

  for (genvar s = 0; s < 3; s++) begin : g_src
    assign ready[s]     = count[s] < DEPTH_C;
    assign push[s]      = in_valid[s] && ready[s];
    assign push_live[s] = !(bus.mispredict && (age_of(in_p[s].rob_tag, bus.rob_head) > flush_age));
    assign head_e[s]    = fifo_q[s][rd_ptr[s]];
    assign head_age[s]  = age_of(head_e[s].p.rob_tag, bus.rob_head);
    assign discard[s]   = (count[s] != '0) && !head_e[s].live;
    // A head being squashed this cycle is neither selected nor discarded yet;
    // its cleared live bit gets it discarded on the following cycle.
    assign elig[s]      = (count[s] != '0) && head_e[s].live &&
                          !(bus.mispredict && (head_age[s] > flush_age));
    assign pop[s]       = discard[s] || (sel_any && (sel_idx == 2'(s)));

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        wr_ptr[s] <= '0;
        rd_ptr[s] <= '0;
        count[s]  <= '0;
      end else begin
        if (push[s]) wr_ptr[s] <= wr_ptr[s] + 1'b1;
        if (pop[s])  rd_ptr[s] <= rd_ptr[s] + 1'b1;
        case ({push[s], pop[s]})
          2'b10:   count[s] <= count[s] + 1'b1;
          2'b01:   count[s] <= count[s] - 1'b1;
          default: count[s] <= count[s];
        endcase
      end
    end

    for (genvar e = 0; e < FIFO_DEPTH; e++) begin : g_ent
      localparam logic [PW-1:0] IDX = PW'(e);
      always_ff @(posedge clk) begin
        if (push[s] && (wr_ptr[s] == IDX)) begin
          fifo_q[s][e] <= '{p: in_p[s], live: push_live[s]};
        end else if (bus.mispredict &&
                     (age_of(fifo_q[s][e].p.rob_tag, bus.rob_head) > flush_age)) begin
          fifo_q[s][e].live <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    sel_any  = 1'b0;
    sel_idx  = 2'd0;
    best_age = '1;
    if (elig[0]) begin
      sel_any  = 1'b1;
      sel_idx  = 2'd0;
      best_age = head_age[0];
    end
    if (elig[1] && (!sel_any || (head_age[1] < best_age))) begin
      sel_any  = 1'b1;
      sel_idx  = 2'd1;
      best_age = head_age[1];
    end
    if (elig[2] && (!sel_any || (head_age[2] < best_age))) begin
      sel_any  = 1'b1;
      sel_idx  = 2'd2;
      best_age = head_age[2];
    end
    case (sel_idx)
      2'd1:    sel_p = head_e[1].p;
      2'd2:    sel_p = head_e[2].p;
      default: sel_p = head_e[0].p;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cdb_valid_q <= 1'b0;
      cdb_q       <= '0;
    end else begin
      cdb_valid_q <= sel_any;
      if (sel_any) cdb_q <= sel_p;
    end
  end

  assign bus.alu_ready   = ready[0];
  assign bus.b_ready     = ready[1];
  assign bus.mem_ready   = ready[2];
  assign bus.cdb_valid   = cdb_valid_q;
  assign bus.cdb_rob_tag = cdb_q.rob_tag;
  assign bus.cdb_pd      = cdb_q.pd;
  assign bus.cdb_data    = cdb_q.data;
  assign bus.cdb_we      = cdb_q.we;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: vector table, directed corner-case
// sequences and a randomized run against a queue-based reference model.
module tb_cdb_arbiter;
  localparam int unsigned D = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cdb_arbiter_if bus ();
  cdb_arbiter #(.FIFO_DEPTH(D)) dut (.clk(clk), .reset(reset), .bus(bus));

  logic        in_v    [3];
  logic [4:0]  in_tag  [3];
  logic [6:0]  in_pd   [3];
  logic [31:0] in_data [3];
  logic        in_we   [3];
  logic [4:0]  head;
  logic        mp;
  logic [4:0]  mtag;

  assign bus.alu_valid = in_v[0];   assign bus.b_valid = in_v[1];   assign bus.mem_valid = in_v[2];
  assign bus.alu_rob_tag = in_tag[0]; assign bus.b_rob_tag = in_tag[1]; assign bus.mem_rob_tag = in_tag[2];
  assign bus.alu_pd = in_pd[0];     assign bus.b_pd = in_pd[1];     assign bus.mem_pd = in_pd[2];
  assign bus.alu_data = in_data[0]; assign bus.b_data = in_data[1]; assign bus.mem_data = in_data[2];
  assign bus.alu_we = in_we[0];     assign bus.b_we = in_we[1];     assign bus.mem_we = in_we[2];
  assign bus.rob_head = head;
  assign bus.mispredict = mp;
  assign bus.mispredict_tag = mtag;

  int checks = 0;
  int errors = 0;

  function automatic logic [6:0]  pd_of(input logic [4:0] t);   return {2'b01, t}; endfunction
  function automatic logic [31:0] data_of(input logic [4:0] t); return {16'hC0DE, 3'b000, t, 8'h5A}; endfunction
  function automatic logic        we_of(input logic [4:0] t);   return ~t[1]; endfunction
  function automatic int age(input logic [4:0] t, input logic [4:0] h);
    return (int'(t) - int'(h) + 32) % 32;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_in();
    for (int s = 0; s < 3; s++) begin
      in_v[s] = 1'b0; in_tag[s] = '0; in_pd[s] = '0; in_data[s] = '0; in_we[s] = 1'b0;
    end
    mp = 1'b0;
    mtag = '0;
  endtask

  task automatic offer(input int s, input logic [4:0] t);
    in_v[s] = 1'b1; in_tag[s] = t; in_pd[s] = pd_of(t); in_data[s] = data_of(t); in_we[s] = we_of(t);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_cdb(input string name, input logic v, input logic [4:0] t);
    if (v)
      check(name, {bus.cdb_valid, bus.cdb_rob_tag, bus.cdb_pd, bus.cdb_data, bus.cdb_we},
                  {1'b1, t, pd_of(t), data_of(t), we_of(t)});
    else
      check(name, 64'(bus.cdb_valid), 64'd0);
  endtask

  function automatic logic [2:0] dut_ready();
    return {bus.mem_ready, bus.b_ready, bus.alu_ready};
  endfunction

  // ---------------- reference model ----------------
  typedef struct {
    logic [4:0]  tag;
    logic [6:0]  pd;
    logic [31:0] data;
    logic        we;
    bit          live;
  } ment_t;

  ment_t       mq [3][D];
  int          mcnt [3];
  logic        m_v;
  logic [4:0]  m_tag;
  logic [6:0]  m_pd;
  logic [31:0] m_data;
  logic        m_we;

  task automatic model_step();
    int fa, best, ba;
    bit rdy [3];
    fa = age(mtag, head);
    best = -1;
    ba = 99;
    for (int s = 0; s < 3; s++) rdy[s] = mcnt[s] < D;
    for (int s = 0; s < 3; s++)
      if (mcnt[s] > 0 && mq[s][0].live && !(mp && age(mq[s][0].tag, head) > fa) &&
          age(mq[s][0].tag, head) < ba) begin
        best = s;
        ba = age(mq[s][0].tag, head);
      end
    m_v = (best >= 0);
    if (m_v) begin
      m_tag = mq[best][0].tag; m_pd = mq[best][0].pd; m_data = mq[best][0].data; m_we = mq[best][0].we;
    end
    for (int s = 0; s < 3; s++)
      if (mcnt[s] > 0 && (s == best || !mq[s][0].live)) begin
        for (int i = 0; i < D - 1; i++) mq[s][i] = mq[s][i+1];
        mcnt[s]--;
      end
    if (mp)
      for (int s = 0; s < 3; s++)
        for (int i = 0; i < mcnt[s]; i++)
          if (age(mq[s][i].tag, head) > fa) mq[s][i].live = 1'b0;
    for (int s = 0; s < 3; s++)
      if (in_v[s] && rdy[s]) begin
        mq[s][mcnt[s]] = '{in_tag[s], in_pd[s], in_data[s], in_we[s], !(mp && age(in_tag[s], head) > fa)};
        mcnt[s]++;
      end
  endtask

  function automatic bit tag_busy(input logic [4:0] t, input int upto);
    for (int s = 0; s < 3; s++)
      for (int i = 0; i < mcnt[s]; i++)
        if (mq[s][i].tag == t) return 1'b1;
    for (int s = 0; s < upto; s++)
      if (in_v[s] && in_tag[s] == t) return 1'b1;
    return 1'b0;
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic [2:0] v;        // {mem, b, alu} offers
    logic [4:0] ta, tb, tm;
    logic [4:0] hd;
    logic       ev;
    logic [4:0] et;       // expected cdb tag (held value when ev = 0)
  } vec_t;

  vec_t vecs [15];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{3'b101, 5'd2, 5'd0,  5'd31, 5'd30, 1'b0, 5'd0};
    vecs[1]  = '{3'b000, 5'd0, 5'd0,  5'd0,  5'd30, 1'b1, 5'd31};
    vecs[2]  = '{3'b000, 5'd0, 5'd0,  5'd0,  5'd30, 1'b1, 5'd2};
    vecs[3]  = '{3'b000, 5'd0, 5'd0,  5'd0,  5'd30, 1'b0, 5'd2};
    vecs[4]  = '{3'b111, 5'd7, 5'd5,  5'd6,  5'd0,  1'b0, 5'd2};
    vecs[5]  = '{3'b000, 5'd0, 5'd0,  5'd0,  5'd0,  1'b1, 5'd5};
    vecs[6]  = '{3'b000, 5'd0, 5'd0,  5'd0,  5'd0,  1'b1, 5'd6};
    vecs[7]  = '{3'b000, 5'd0, 5'd0,  5'd0,  5'd0,  1'b1, 5'd7};
    vecs[8]  = '{3'b011, 5'd9, 5'd12, 5'd0,  5'd10, 1'b0, 5'd7};
    vecs[9]  = '{3'b000, 5'd0, 5'd0,  5'd0,  5'd10, 1'b1, 5'd12};
    vecs[10] = '{3'b000, 5'd0, 5'd0,  5'd0,  5'd10, 1'b1, 5'd9};
    vecs[11] = '{3'b001, 5'd1, 5'd0,  5'd0,  5'd0,  1'b0, 5'd9};
    vecs[12] = '{3'b001, 5'd3, 5'd0,  5'd0,  5'd0,  1'b1, 5'd1};
    vecs[13] = '{3'b000, 5'd0, 5'd0,  5'd0,  5'd0,  1'b1, 5'd3};
    vecs[14] = '{3'b000, 5'd0, 5'd0,  5'd0,  5'd0,  1'b0, 5'd3};

    clear_in();
    head  = '0;
    reset = 1'b0;
    #12;
    check("reset_cdb", {bus.cdb_valid, bus.cdb_rob_tag, bus.cdb_pd, bus.cdb_data, bus.cdb_we}, 64'd0);
    check("reset_ready", 64'(dut_ready()), 64'h7);
    reset = 1'b1;

    // table: wraparound age priority, three-way ordering, hold, push+pop
    for (int i = 0; i < 15; i++) begin
      clear_in();
      head = vecs[i].hd;
      if (vecs[i].v[0]) offer(0, vecs[i].ta);
      if (vecs[i].v[1]) offer(1, vecs[i].tb);
      if (vecs[i].v[2]) offer(2, vecs[i].tm);
      tick();
      if (vecs[i].ev) expect_cdb($sformatf("vec%0d", i), 1'b1, vecs[i].et);
      else check($sformatf("vec%0d_hold", i), {bus.cdb_valid, bus.cdb_rob_tag}, {1'b0, vecs[i].et});
      check($sformatf("vec%0d_ready", i), 64'(dut_ready()), 64'h7);
    end

    // single result with specific payload, one-cycle latency
    clear_in(); head = 5'd0;
    offer(0, 5'd3); in_pd[0] = 7'd9; in_data[0] = 32'hDEADBEEF; in_we[0] = 1'b1;
    tick();
    check("single_no_bypass", 64'(bus.cdb_valid), 64'd0);
    clear_in(); tick();
    check("single_bcast", {bus.cdb_valid, bus.cdb_rob_tag, bus.cdb_pd, bus.cdb_data, bus.cdb_we},
                          {1'b1, 5'd3, 7'd9, 32'hDEADBEEF, 1'b1});
    tick();
    check("single_done", 64'(bus.cdb_valid), 64'd0);

    // flush of buffered ALU tags 6 and 8 behind an older B stream
    clear_in(); offer(1, 5'd0); offer(0, 5'd4); tick(); expect_cdb("flush_e0", 1'b0, 5'd0);
    clear_in(); offer(1, 5'd1); offer(0, 5'd6); tick(); expect_cdb("flush_b0", 1'b1, 5'd0);
    clear_in(); offer(1, 5'd2); offer(0, 5'd8); tick(); expect_cdb("flush_b1", 1'b1, 5'd1);
    clear_in(); mp = 1'b1; mtag = 5'd5;        tick(); expect_cdb("flush_b2", 1'b1, 5'd2);
    clear_in();                                tick(); expect_cdb("flush_alu4", 1'b1, 5'd4);
    for (int k = 0; k < 3; k++) begin
      tick(); expect_cdb($sformatf("flush_drop%0d", k), 1'b0, 5'd0);
    end
    check("flush_ready", 64'(dut_ready()), 64'h7);

    // backpressure: B stream keeps the CDB busy while ALU fills
    for (int k = 0; k < 7; k++) begin
      clear_in();
      if (k < 6) offer(1, 5'(k));
      if (k < 4) offer(0, 5'(10 + k)); else offer(0, 5'd14);
      tick();
      if (k == 0) expect_cdb("bp_e0", 1'b0, 5'd0);
      else expect_cdb($sformatf("bp_b%0d", k - 1), 1'b1, 5'(k - 1));
      check($sformatf("bp_ready%0d", k), 64'(bus.alu_ready), (k < 3) ? 64'd1 : 64'd0);
    end
    clear_in(); tick();
    expect_cdb("bp_alu10", 1'b1, 5'd10);
    check("bp_ready_after_pop", 64'(bus.alu_ready), 64'd1);
    for (int k = 11; k < 14; k++) begin
      tick(); expect_cdb($sformatf("bp_alu%0d", k), 1'b1, 5'(k));
    end
    tick(); expect_cdb("bp_no14", 1'b0, 5'd0);

    // flush at push
    clear_in(); mp = 1'b1; mtag = 5'd10; offer(1, 5'd12); tick(); expect_cdb("fp_e0", 1'b0, 5'd0);
    clear_in(); tick(); expect_cdb("fp_no12a", 1'b0, 5'd0);
    tick(); expect_cdb("fp_no12b", 1'b0, 5'd0);
    clear_in(); mp = 1'b1; mtag = 5'd10; offer(1, 5'd10); tick(); expect_cdb("fp_e1", 1'b0, 5'd0);
    clear_in(); tick(); expect_cdb("fp_tag10", 1'b1, 5'd10);
    tick(); expect_cdb("fp_done", 1'b0, 5'd0);

    // asynchronous reset mid-operation
    clear_in(); offer(0, 5'd1); offer(1, 5'd2); offer(2, 5'd3); tick();
    clear_in(); offer(0, 5'd4); offer(1, 5'd5); offer(2, 5'd6); tick();
    expect_cdb("ar_pre", 1'b1, 5'd1);
    clear_in();
    #3 reset = 1'b0;
    #1;
    check("ar_cdb_now", {bus.cdb_valid, bus.cdb_rob_tag, bus.cdb_pd, bus.cdb_data, bus.cdb_we}, 64'd0);
    check("ar_ready_now", 64'(dut_ready()), 64'h7);
    tick();
    #2 reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("ar_post%0d", k), {bus.cdb_valid, dut_ready()}, {1'b0, 3'b111});
    end

    // randomized run against the reference model (state is fresh after reset)
    for (int s = 0; s < 3; s++) mcnt[s] = 0;
    m_v = 1'b0; m_tag = '0; m_pd = '0; m_data = '0; m_we = 1'b0;
    head = '0;
    for (int c = 0; c < 400; c++) begin
      clear_in();
      for (int s = 0; s < 3; s++)
        if ($urandom_range(0, 1) == 1)
          for (int tr = 0; tr < 64; tr++) begin
            logic [4:0] t;
            t = 5'($urandom_range(0, 31));
            if (!tag_busy(t, s)) begin
              offer(s, t);
              break;
            end
          end
      mp   = ($urandom_range(0, 11) == 0);
      mtag = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 9) == 0) head = 5'($urandom_range(0, 31));
      model_step();
      tick();
      check($sformatf("rand%0d", c),
            {bus.cdb_valid, bus.cdb_rob_tag, bus.cdb_pd, bus.cdb_data, bus.cdb_we, dut_ready()},
            {m_v, m_tag, m_pd, m_data, m_we,
             mcnt[2] < D, mcnt[1] < D, mcnt[0] < D});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning the per-source buffer depth in entries (power of two, >=2).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on the rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 SHALL have ports {alu,b,mem}_valid, input, 1 each, meaning a functional-unit completion is offered this cycle.
REQ-005 SHALL have ports {alu,b,mem}_rob_tag (5), _pd (7), _data (32) and _we (1), all inputs, meaning ROB tag, destination physical register, result, and PRF write enable.
REQ-006 SHALL have ports {alu,b,mem}_ready, output, 1 each, meaning that source's FIFO can accept an entry.
REQ-007 SHALL have port rob_head, input, 5, meaning the oldest in-flight ROB tag.
REQ-008 SHALL have ports mispredict (input, 1) and mispredict_tag (input, 5), meaning a branch flush of all entries younger than the tag.
REQ-009 SHALL have ports cdb_valid (1), cdb_rob_tag (5), cdb_pd (7), cdb_data (32) and cdb_we (1), all outputs, forming the registered common-data-bus broadcast.

Function
REQ-010 SHALL keep one in-order FIFO of FIFO_DEPTH entries per source; each entry holds rob_tag, pd, data, we and a live bit.
REQ-011 SHALL push an entry when x_valid && x_ready. An offer while x_ready=0 is ignored, and the FU holds it.
REQ-012 SHALL drive x_ready = (count_x < FIFO_DEPTH) from registered state only. A pop in the same cycle does not raise ready.
REQ-013 SHALL compute age(t) = (t - rob_head) mod 32 in 5-bit wraparound arithmetic. Entry t is younger than m iff age(t) > age(m).
REQ-014 SHALL, on a cycle with mispredict=1, clear the live bit of every stored entry younger than mispredict_tag. An entry at exactly mispredict_tag stays live.
REQ-015 SHALL, on a cycle with mispredict=1, push an incoming entry younger than mispredict_tag with live=0.
REQ-016 SHALL, each cycle, pop and discard a non-live head entry from each source independently, without using the CDB.
REQ-017 SHALL select at most one live head per cycle across the three sources. The winner is the smallest age(); ROB tags are unique, so no tie occurs.
REQ-018 SHALL exclude from selection, in a mispredict cycle, any head younger than mispredict_tag.
REQ-019 SHALL pop the selected head and register it onto the cdb_* outputs with cdb_valid=1 on the next edge. If nothing is selected, it SHALL register cdb_valid=0.
REQ-020 SHALL hold cdb_rob_tag, cdb_pd, cdb_data and cdb_we at their previous values when cdb_valid=0.
REQ-021 SHALL give one-cycle latency: an entry pushed at edge N into an empty system appears with cdb_valid=1 after edge N+1. There is no bypass from input to cdb.
REQ-022 SHALL leave an already-registered cdb broadcast unchanged when a mispredict arrives in the same cycle.
REQ-023 SHALL wrap FIFO pointers modulo FIFO_DEPTH. A simultaneous push and pop on a full FIFO is impossible, because ready=0 blocks the push.
REQ-024 SHALL pass data and we through unmodified. cdb_we=0 entries, such as stores and branches without a destination, still broadcast to mark ROB completion.

Reset
REQ-025 SHALL, while reset=0, asynchronously empty all FIFOs and clear all pointers and counts.
REQ-026 SHALL, while reset=0, drive cdb_valid=0 and cdb_rob_tag=0, cdb_pd=0, cdb_data=0, cdb_we=0.
REQ-027 SHALL, while reset=0, drive all x_ready outputs to 1.
REQ-028 SHALL, when reset is asserted mid-operation, discard all buffered and in-flight entries with no broadcast.
REQ-029 SHALL begin normal operation on the first rising edge after reset deasserts.

Verification
REQ-030 Bench SHALL cover single result: rob_head=0; ALU offers tag 3, pd 9, data 0xDEADBEEF, we=1 at edge N -> cdb_valid=1 with those values after N+1, and cdb_valid=0 after N+2.
REQ-031 Bench SHALL cover age priority with wraparound: rob_head=30; ALU tag 2 and MEM tag 31 offered in the same cycle -> tag 31 broadcasts first, then tag 2.
REQ-032 Bench SHALL cover flush: rob_head=0; buffered ALU tags 4, 6, 8; mispredict with tag 5 -> only tag 4 broadcasts, and tags 6 and 8 are dropped within 2 cycles with no cdb_valid.
REQ-033 Bench SHALL cover backpressure: hold the CDB busy with an older B stream and fill ALU with 4 entries -> alu_ready=0; once 1 entry is popped, alu_ready=1 the next cycle.
REQ-034 Bench SHALL cover flush at push: mispredict with tag 10 in the same cycle that B offers tag 12 -> tag 12 is never broadcast; a tag-10 offer in the same situation IS broadcast.
REQ-035 Bench SHALL cover asynchronous reset: assert reset=0 between clock edges with 3 entries buffered -> cdb_valid=0 immediately, all readies=1, and no broadcast after release.
